// File: rtl/lc3_alu_issue.sv
// lc3_alu_issue: issue/writeback sequencer for the LC-3 ALU. It decodes ADD/AND/NOT/BR, reads
// operands from an 8x16 register file and retires ALU results into that file and the condition codes.
`default_nettype none

module lc3_alu_issue #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_nzp,
  output logic        done,
  output logic        br_taken,
  output logic        illegal,
  output logic [2:0]  cc,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int              CW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0]   CNT_END = CW'(ALU_LAT - 1);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [15:0]   rf [8];
  // Only the opcode and the destination/condition field are needed after issue.
  logic [3:0]    ir_op;
  logic [2:0]    ir_dst;
  logic [15:0]   b_dec;
  logic          in_operate;
  logic          ir_operate;

  function automatic logic is_operate(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  always_comb begin
    in_operate = is_operate(instr[15:12]);
    ir_operate = is_operate(ir_op);
    b_dec      = 16'h0000;
    if (instr[15:12] != OP_NOT) begin
      b_dec = instr[5] ? {{11{instr[4]}}, instr[4:0]} : rf[instr[2:0]];
    end
  end

  assign instr_ready = (state == IDLE);
  assign done        = (state == RESP);
  assign br_taken    = (state == RESP) && (ir_op == OP_BR) && (|(ir_dst & cc));
  assign illegal     = (state == RESP) && !ir_operate && (ir_op != OP_BR);
  assign dbg_data    = rf[dbg_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cc         <= 3'b010;
      ir_op      <= 4'h0;
      ir_dst     <= 3'h0;
      alu_a      <= 16'h0000;
      alu_b      <= 16'h0000;
      alu_opcode <= 4'h0;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 16'h0000;
      end
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir_op      <= instr[15:12];
            ir_dst     <= instr[11:9];
            alu_a      <= rf[instr[8:6]];
            alu_b      <= b_dec;
            alu_opcode <= instr[15:12];
            cnt        <= '0;
            state      <= in_operate ? EXEC : RESP;
          end
        end
        EXEC: begin
          if (cnt == CNT_END) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // Retire before returning to IDLE so the next accepted instruction sees fresh state.
          if (ir_operate) begin
            rf[ir_dst] <= alu_out;
            cc         <= alu_nzp;
          end
          alu_a      <= 16'h0000;
          alu_b      <= 16'h0000;
          alu_opcode <= 4'h0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lc3_alu_issue.sv
// tb_lc3_alu_issue: directed bench for lc3_alu_issue with a one-cycle behavioural ALU attached.
`default_nettype none

module tb_lc3_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_out;
  logic [2:0]  alu_nzp;
  logic        done;
  logic        br_taken;
  logic        illegal;
  logic [2:0]  cc;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int vectors = 0;
  int errors  = 0;

  lc3_alu_issue #(.ALU_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_out     (alu_out),
    .alu_nzp     (alu_nzp),
    .done        (done),
    .br_taken    (br_taken),
    .illegal     (illegal),
    .cc          (cc),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'b0001: return a + b;
      4'b0101: return a & b;
      4'b1001: return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [2:0] nzp_f(input logic [15:0] r);
    if (r[15])          return 3'b100;
    else if (r == 16'h0) return 3'b010;
    else                return 3'b001;
  endfunction

  // Registered ALU: result valid one cycle after its inputs are driven.
  always_ff @(posedge clk) begin
    alu_out <= alu_f(alu_opcode, alu_a, alu_b);
    alu_nzp <= nzp_f(alu_f(alu_opcode, alu_a, alu_b));
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after RESP.
  task automatic issue_op(input logic [15:0] word, input logic [15:0] exp_a, input logic [15:0] exp_b,
                          input logic [2:0] dst, input logic [15:0] exp_val, input logic [2:0] exp_cc);
    check("ready_before", {15'd0, instr_ready}, 16'd1);
    instr_valid = 1'b1;
    instr       = word;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    check("exec_ready", {15'd0, instr_ready}, 16'd0);
    check("exec_done", {15'd0, done}, 16'd0);
    check("exec_a", alu_a, exp_a);
    check("exec_b", alu_b, exp_b);
    check("exec_op", {12'd0, alu_opcode}, {12'd0, word[15:12]});
    @(negedge clk);
    check("resp_done", {15'd0, done}, 16'd1);
    check("resp_ready", {15'd0, instr_ready}, 16'd0);
    check("resp_a_held", alu_a, exp_a);
    check("resp_illegal", {15'd0, illegal}, 16'd0);
    @(negedge clk);
    dbg_sel = dst;
    #1;
    check("post_ready", {15'd0, instr_ready}, 16'd1);
    check("post_done", {15'd0, done}, 16'd0);
    check("post_a_zero", alu_a, 16'h0000);
    check("wb_reg", dbg_data, exp_val);
    check("wb_cc", {13'd0, cc}, {13'd0, exp_cc});
  endtask

  // BR or illegal opcode: done one cycle after acceptance.
  task automatic issue_short(input logic [15:0] word, input logic exp_taken, input logic exp_illegal,
                             input logic [2:0] exp_cc);
    check("short_ready", {15'd0, instr_ready}, 16'd1);
    instr_valid = 1'b1;
    instr       = word;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    check("short_done", {15'd0, done}, 16'd1);
    check("short_taken", {15'd0, br_taken}, {15'd0, exp_taken});
    check("short_illegal", {15'd0, illegal}, {15'd0, exp_illegal});
    check("short_ready_low", {15'd0, instr_ready}, 16'd0);
    @(negedge clk);
    check("short_after_done", {15'd0, done}, 16'd0);
    check("short_after_ready", {15'd0, instr_ready}, 16'd1);
    check("short_cc", {13'd0, cc}, {13'd0, exp_cc});
  endtask

  initial begin
    logic [15:0] regs_exp [8];
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_sel     = 3'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cc", {13'd0, cc}, 16'h0002);
    check("rst_ready", {15'd0, instr_ready}, 16'd1);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_br", {15'd0, br_taken}, 16'd0);
    check("rst_illegal", {15'd0, illegal}, 16'd0);
    check("rst_alu_a", alu_a, 16'h0000);
    check("rst_alu_b", alu_b, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check("rst_reg", dbg_data, 16'h0000);
    end
    @(negedge clk);

    issue_op(16'h5020, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'b010);
    issue_op(16'h1225, 16'h0000, 16'h0005, 3'd1, 16'h0005, 3'b001);
    issue_op(16'h1479, 16'h0005, 16'hFFF9, 3'd2, 16'hFFFE, 3'b100);
    issue_op(16'h96BF, 16'hFFFE, 16'h0000, 3'd3, 16'h0001, 3'b001);
    issue_op(16'h1843, 16'h0005, 16'h0001, 3'd4, 16'h0006, 3'b001);

    issue_short(16'h0203, 1'b1, 1'b0, 3'b001);
    issue_short(16'h0803, 1'b0, 1'b0, 3'b001);
    issue_short(16'h0003, 1'b0, 1'b0, 3'b001);
    issue_short(16'h6000, 1'b0, 1'b1, 3'b001);

    regs_exp = '{16'h0000, 16'h0005, 16'hFFFE, 16'h0001, 16'h0006, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check("regs_after_illegal", dbg_data, regs_exp[i]);
    end

    // Reset while the ADD is in EXEC must suppress retirement.
    instr_valid = 1'b1;
    instr       = 16'h1225;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    check("mid_exec_ready", {15'd0, instr_ready}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_done2", {15'd0, done}, 16'd0);
    check("mid_rst_ready", {15'd0, instr_ready}, 16'd1);
    check("mid_rst_cc", {13'd0, cc}, 16'h0002);
    dbg_sel = 3'd1;
    #1;
    check("mid_rst_r1", dbg_data, 16'h0000);
    dbg_sel = 3'd4;
    #1;
    check("mid_rst_r4", dbg_data, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
